bias_seq_ctrl: RTL and testbench

Sequencer that streams one layer's per-kernel bias coefficients from a synchronous bias ROM into an ap_fifo output stream. It emits the full bias vector (KERN words) once per output pixel, REPEAT times per frame, under ap_ctrl_hs start/done control. It absorbs the ROM read latency and FIFO backpressure without losing or duplicating words. It sits between the layer's bias ROM and the accumulator stage of a conv layer.

---
 rtl/bias_seq_ctrl_pkg.sv | 21 ++
 rtl/bias_skid_buf.sv | 49 ++++
 rtl/bias_seq_ctrl.sv | 115 +++++++++++
 tb/tb_bias_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared sizes and types for the bias sequencer.
// Holds the layer coefficient width, the default per-layer kernel/repeat
// counts, the sequencer state encoding and the ROM address-width helper.
package bias_seq_ctrl_pkg;

  localparam int COEFF_WIDTH = 16;
  localparam int BIAS_KERN   = 16;
  localparam int BIAS_REPEAT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  // A one-word ROM still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bias_skid_buf.sv
// Two-entry in-order FIFO that absorbs the ROM read latency and downstream
// backpressure for the bias sequencer.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   push, din write one word (caller guarantees room)
//   pop       retire the head word (caller guarantees non-empty)
//   count     occupancy 0..2
//   head      oldest word
module bias_skid_buf
  import bias_seq_ctrl_pkg::*;
#(
  parameter int W = COEFF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Entries are cleared too so the stream data output reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias sequencer: streams KERN bias words from a synchronous ROM into an
// ap_fifo stream, REPEAT times per frame, under ap_ctrl_hs handshaking.
// Ports:
//   ap_clk, ap_rst              clock, asynchronous active-high reset
//   ap_start/done/idle/ready    block-level handshake
//   bias_V_address0/ce0/q0      ROM read port (1-cycle latency)
//   output_V_din/full_n/write   output stream
module bias_seq_ctrl
  import bias_seq_ctrl_pkg::*;
#(
  parameter int KERN    = BIAS_KERN,
  parameter int REPEAT  = BIAS_REPEAT,
  parameter int COEFF_W = COEFF_WIDTH,
  parameter int AW      = addr_width(KERN)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic [AW-1:0]      bias_V_address0,
  output logic               bias_V_ce0,
  input  logic [COEFF_W-1:0] bias_V_q0,
  output logic [COEFF_W-1:0] output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int            PW     = $clog2(REPEAT + 1);
  localparam logic [AW-1:0] K_LAST = AW'(KERN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(REPEAT - 1);

  seq_state_t    state;
  logic [AW-1:0] k_cnt;
  logic [PW-1:0] p_cnt;
  logic          inflight;
  logic [1:0]    buf_count;
  logic [2:0]    pending;
  logic          pop;
  logic          issue;
  logic          last_issue;
  logic          last_word;

  // Stage 0: issue. A read may only go out if its word is guaranteed a slot
  // when it lands next cycle, counting what is buffered, what is already in
  // flight and what leaves this cycle.
  assign pop        = (buf_count != 2'd0) && output_V_full_n;
  assign pending    = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == ST_RUN) && (pending < 3'd2);
  assign last_issue = issue && (k_cnt == K_LAST) && (p_cnt == P_LAST);

  // The final word of the frame is the one leaving an otherwise empty pipe.
  assign last_word  = (state == ST_DRAIN) && pop && (buf_count == 2'd1) && !inflight;

  assign bias_V_ce0      = issue;
  assign bias_V_address0 = k_cnt;
  assign output_V_write  = pop;
  assign ap_done         = last_word;
  assign ap_ready        = last_word;
  assign ap_idle         = (state == ST_IDLE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ST_IDLE;
      k_cnt    <= '0;
      p_cnt    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            state <= ST_RUN;
            k_cnt <= '0;
            p_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (k_cnt == K_LAST) begin
              k_cnt <= '0;
              p_cnt <= p_cnt + 1'b1;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
            if (last_issue) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_word) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: ROM data returns one cycle after issue and is captured here.
  bias_skid_buf #(
    .W(COEFF_W)
  ) u_skid (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (inflight),
    .din   (bias_V_q0),
    .pop   (pop),
    .count (buf_count),
    .head  (output_V_din)
  );

endmodule

// File: tb/tb_bias_seq_ctrl.sv
module tb_bias_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // ---------------- instance A: KERN=4, REPEAT=2, ROM={10,20,30,40}
  logic        a_rst = 1'b1, a_start = 1'b0, a_full_n = 1'b1;
  logic        a_done, a_idle, a_ready, a_ce0, a_write;
  logic [1:0]  a_addr;
  logic [15:0] a_q0 = '0, a_din;

  bias_seq_ctrl #(.KERN(4), .REPEAT(2), .COEFF_W(16)) dut_a (
    .ap_clk(clk), .ap_rst(a_rst), .ap_start(a_start), .ap_done(a_done),
    .ap_idle(a_idle), .ap_ready(a_ready), .bias_V_address0(a_addr),
    .bias_V_ce0(a_ce0), .bias_V_q0(a_q0), .output_V_din(a_din),
    .output_V_full_n(a_full_n), .output_V_write(a_write));

  always @(posedge clk) if (a_ce0) a_q0 <= 16'(10 * (int'(a_addr) + 1));

  // ---------------- instance B: KERN=16, REPEAT=37, ROM[i]=3i+1
  logic        bc_rst = 1'b1;
  logic        b_start = 1'b0, b_full_n = 1'b1;
  logic        b_done, b_idle, b_ready, b_ce0, b_write;
  logic [3:0]  b_addr;
  logic [15:0] b_q0 = '0, b_din;

  bias_seq_ctrl #(.KERN(16), .REPEAT(37), .COEFF_W(16)) dut_b (
    .ap_clk(clk), .ap_rst(bc_rst), .ap_start(b_start), .ap_done(b_done),
    .ap_idle(b_idle), .ap_ready(b_ready), .bias_V_address0(b_addr),
    .bias_V_ce0(b_ce0), .bias_V_q0(b_q0), .output_V_din(b_din),
    .output_V_full_n(b_full_n), .output_V_write(b_write));

  always @(posedge clk) if (b_ce0) b_q0 <= 16'(3 * int'(b_addr) + 1);

  // ---------------- instance C: KERN=1, REPEAT=3, ROM={7}
  logic        c_start = 1'b0, c_full_n = 1'b1;
  logic        c_done, c_idle, c_ready, c_ce0, c_write;
  logic [0:0]  c_addr;
  logic [15:0] c_q0 = '0, c_din;

  bias_seq_ctrl #(.KERN(1), .REPEAT(3), .COEFF_W(16)) dut_c (
    .ap_clk(clk), .ap_rst(bc_rst), .ap_start(c_start), .ap_done(c_done),
    .ap_idle(c_idle), .ap_ready(c_ready), .bias_V_address0(c_addr),
    .bias_V_ce0(c_ce0), .bias_V_q0(c_q0), .output_V_din(c_din),
    .output_V_full_n(c_full_n), .output_V_write(c_write));

  always @(posedge clk) if (c_ce0) c_q0 <= 16'd7;

  // ---------------- scoreboards / monitors
  logic [15:0] a_sb[$], b_sb[$], c_sb[$];
  int a_wr = 0, a_dn = 0, a_out = 0;
  int b_wr = 0, b_dn = 0, b_out = 0;
  int c_wr = 0, c_dn = 0;

  always @(negedge clk) begin
    if (a_rst) a_out = 0;
    else a_out = a_out + int'(a_ce0) - int'(a_write);
    if (a_write) begin
      a_wr++;
      if (a_sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_stream: got unexpected word %0d, expected no write", a_din);
      end else chk("a_stream", a_din, a_sb.pop_front());
    end
    if (a_done) begin
      a_dn++;
      chk("a_done_with_write", a_write, 1);
      chk("a_ready_eq_done", a_ready, 1);
    end
    if (!a_rst) chk("a_outstanding_le2", (a_out <= 2), 1);
  end

  always @(negedge clk) begin
    if (bc_rst) b_out = 0;
    else b_out = b_out + int'(b_ce0) - int'(b_write);
    if (b_write) begin
      b_wr++;
      if (b_sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_stream: got unexpected word %0d, expected no write", b_din);
      end else chk("b_stream", b_din, b_sb.pop_front());
    end
    if (b_done) begin
      b_dn++;
      chk("b_done_with_write", b_write, 1);
    end
    if (!bc_rst) chk("b_outstanding_le2", (b_out <= 2), 1);
  end

  always @(negedge clk) begin
    if (c_ce0) chk("c_addr_const0", c_addr, 0);
    if (c_write) begin
      c_wr++;
      if (c_sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL c_stream: got unexpected word %0d, expected no write", c_din);
      end else chk("c_stream", c_din, c_sb.pop_front());
    end
    if (c_done) begin
      c_dn++;
      chk("c_done_with_write", c_write, 1);
    end
  end

  // ---------------- helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  typedef struct {
    string name;
    int    lo_from;     // first cycle after start with full_n low
    int    lo_to;       // last low cycle (lo_to < lo_from: no stall)
    int    start_at;    // cycle with an extra ap_start pulse (0: none)
    int    ce0_drop;    // check ce0=0 from lo_from+1 to lo_to
    int    exp_first;   // expected cycle of the first write
    int    exp_done;    // expected cycle of ap_done
  } vec_t;

  function automatic vec_t mk(input string n, input int f, input int t, input int s,
                              input int d, input int ef, input int ed);
    vec_t v;
    v.name = n; v.lo_from = f; v.lo_to = t; v.start_at = s;
    v.ce0_drop = d; v.exp_first = ef; v.exp_done = ed;
    return v;
  endfunction

  task automatic push_a_frame();
    for (int k = 0; k < 8; k++) a_sb.push_back(16'(10 * ((k % 4) + 1)));
  endtask

  // Cycle c spans edge E(c-1)..E(c), where E0 is the edge that samples ap_start.
  task automatic run_a(input vec_t v);
    int first, done_c, d0;
    first = -1; done_c = -1; d0 = a_dn;
    push_a_frame();
    a_start = 1'b1; a_full_n = 1'b1;
    tick();
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      a_start  = (c == v.start_at);
      a_full_n = !(c >= v.lo_from && c <= v.lo_to);
      sample();
      if (c == 1) chk({v.name, "_ce0_c1"}, a_ce0, 1);
      if (first < 0 && a_write) first = c;
      if (v.ce0_drop != 0 && c > v.lo_from && c <= v.lo_to)
        chk({v.name, "_ce0_stalled"}, a_ce0, 0);
      if (a_done) begin
        done_c = c;
        chk({v.name, "_sb_empty_at_done"}, a_sb.size(), 0);
      end
      tick();
    end
    a_start = 1'b0; a_full_n = 1'b1;
    chk({v.name, "_first_write_cycle"}, first, v.exp_first);
    chk({v.name, "_done_cycle"}, done_c, v.exp_done);
    sample();
    chk({v.name, "_idle_after"}, a_idle, 1);
    chk({v.name, "_done_count"}, a_dn - d0, 1);
  endtask

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d1, d2, q1, dn0, cyc;

    tbl[0] = mk("nominal",        0, -1, 0, 0, 3, 10);
    tbl[1] = mk("stall_5_9",      5,  9, 0, 1, 3, 15);
    tbl[2] = mk("stall_1_2",      1,  2, 0, 0, 3, 10);
    tbl[3] = mk("stall_3",        3,  3, 0, 0, 4, 11);
    tbl[4] = mk("stall_4",        4,  4, 0, 0, 3, 11);
    tbl[5] = mk("start_in_run",   0, -1, 4, 0, 3, 10);
    tbl[6] = mk("start_in_drain", 0, -1, 9, 0, 3, 10);

    // ---- reset state
    tick(); tick();
    sample();
    chk("rst_idle", a_idle, 1);
    chk("rst_done", a_done, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_ce0", a_ce0, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_write", a_write, 0);
    chk("rst_din", a_din, 0);
    tick();
    a_rst = 1'b0; bc_rst = 1'b0;
    sample();
    chk("post_rst_idle", a_idle, 1);
    chk("post_rst_ce0", a_ce0, 0);

    // ---- table-driven frames on instance A
    foreach (tbl[i]) run_a(tbl[i]);

    // ---- reset after the 5th write, then a clean restart
    push_a_frame();
    w0 = a_wr; dn0 = a_dn;
    a_start = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      a_start = 1'b0;
      sample();
      tick();
    end
    chk("rst_mid_writes_before", a_wr - w0, 5);
    a_rst = 1'b1;
    a_sb.delete();
    sample();
    chk("rst_mid_write", a_write, 0);
    chk("rst_mid_idle", a_idle, 1);
    chk("rst_mid_ce0", a_ce0, 0);
    tick();
    sample();
    chk("rst_mid_write_hold", a_write, 0);
    tick();
    a_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("rst_mid_no_resume", a_write, 0);
      tick();
    end
    chk("rst_mid_no_done", a_dn - dn0, 0);
    sample();
    run_a(tbl[0]);

    // ---- ap_start held high across two frames
    push_a_frame(); push_a_frame();
    d1 = -1; d2 = -1; q1 = -1;
    a_start = 1'b1;
    tick();
    for (int c = 1; c <= 60 && d2 < 0; c++) begin
      a_start = (c <= 11);
      sample();
      if (a_done) begin
        if (d1 < 0) begin d1 = c; q1 = a_sb.size(); end
        else d2 = c;
      end
      tick();
    end
    a_start = 1'b0;
    chk("b2b_done1_cycle", d1, 10);
    chk("b2b_sb_after_done1", q1, 8);
    chk("b2b_done2_cycle", d2, 21);
    chk("b2b_sb_after_done2", a_sb.size(), 0);
    sample();
    chk("b2b_idle_after", a_idle, 1);

    // ---- instance B: random backpressure, 592 words
    for (int p = 0; p < 37; p++)
      for (int k = 0; k < 16; k++) b_sb.push_back(16'(3 * k + 1));
    b_start = 1'b1;
    tick();
    cyc = 0;
    while (b_dn == 0 && cyc < 5000) begin
      b_start  = 1'b0;
      b_full_n = 1'($urandom_range(0, 1));
      sample();
      tick();
      cyc++;
    end
    for (int c = 0; c < 20; c++) begin
      b_full_n = 1'($urandom_range(0, 1));
      sample();
      tick();
    end
    b_full_n = 1'b1;
    chk("b_done_count", b_dn, 1);
    chk("b_word_count", b_wr, 592);
    chk("b_sb_empty", b_sb.size(), 0);
    sample();
    chk("b_idle_after", b_idle, 1);

    // ---- instance C: single-word ROM
    for (int i = 0; i < 3; i++) c_sb.push_back(16'd7);
    d1 = -1;
    c_start = 1'b1;
    tick();
    for (int c = 1; c <= 20 && d1 < 0; c++) begin
      c_start = 1'b0;
      sample();
      if (c_done) d1 = c;
      tick();
    end
    chk("c_done_cycle", d1, 5);
    chk("c_word_count", c_wr, 3);
    chk("c_done_count", c_dn, 1);
    sample();
    chk("c_idle_after", c_idle, 1);

    chk("a_sb_final_empty", a_sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
